// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, control-mode encoding and pointer helper for the CDB arbiter.
package cdb_arbiter_pkg;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_FU_NUM    = 6;
    localparam int DEF_RB_INDEX  = 4;
    localparam int DEF_CDB_PORTS = 2;

    // What the arbiter does at the next edge; flush outranks stall.
    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_STALL,
        MODE_FLUSH
    } cdb_mode_e;

    // Wraps a pointer sum back into 0..n-1; inputs never exceed 2n-2.
    function automatic int unsigned ptr_wrap(input int unsigned p, input int unsigned n);
        return (p >= n) ? (p - n) : p;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: first set bit of i_mask at or after i_start.
import cdb_arbiter_pkg::*;

module cdb_rr_picker #(
    parameter int N  = 6,
    parameter int PW = 3
) (
    input  logic [N-1:0]  i_mask,
    input  logic [PW-1:0] i_start,
    output logic [N-1:0]  o_onehot,
    output logic [PW-1:0] o_index,
    output logic          o_valid
);

    logic [PW-1:0] w_pos;

    // Scan positions start, start+1, ... (mod N) and keep the first eligible one.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
        o_onehot = '0;
        o_index  = '0;
        o_valid  = 1'b0;
        w_pos    = '0;
        for (int i = 0; i < N; i++) begin
            w_pos = PW'(ptr_wrap(int'(i_start) + i, N));
            if (!o_valid && i_mask[w_pos]) begin
                o_valid         = 1'b1;
                o_index         = w_pos;
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing up to CDB_PORTS FU results per cycle onto the CDB.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int FU_NUM    = DEF_FU_NUM,
    parameter int RB_INDEX  = DEF_RB_INDEX,
    parameter logic [RB_INDEX-1:0] NULL = {RB_INDEX{1'b1}},
    parameter int CDB_PORTS = DEF_CDB_PORTS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [FU_NUM-1:0]              fu_req,
    input  logic [WORD_SIZE*FU_NUM-1:0]    fu_data,
    input  logic [RB_INDEX*FU_NUM-1:0]     fu_rb_index,
    input  logic                           cdb_stall,
    output logic [FU_NUM-1:0]              fu_grant,
    output logic [CDB_PORTS-1:0]           cdb_valid,
    output logic [WORD_SIZE*CDB_PORTS-1:0] cdb_data,
    output logic [RB_INDEX*CDB_PORTS-1:0]  cdb_rb_index
);

    localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [PTR_W-1:0]               r_rr_ptr;
    logic [FU_NUM-1:0]              r_grant;
    logic [CDB_PORTS-1:0]           r_cdb_valid;
    logic [WORD_SIZE*CDB_PORTS-1:0] r_cdb_data;
    logic [RB_INDEX*CDB_PORTS-1:0]  r_cdb_rb_index;

    cdb_mode_e                      w_mode;
    logic [FU_NUM-1:0]              w_eligible;
    logic [FU_NUM-1:0]              w_mask      [CDB_PORTS];
    logic [FU_NUM-1:0]              w_onehot    [CDB_PORTS];
    logic [PTR_W-1:0]               w_win_idx   [CDB_PORTS];
    logic [CDB_PORTS-1:0]           w_win_valid;

    logic [CDB_PORTS-1:0]           w_nxt_valid;
    logic [WORD_SIZE*CDB_PORTS-1:0] w_nxt_data;
    logic [RB_INDEX*CDB_PORTS-1:0]  w_nxt_rb_index;
    logic [FU_NUM-1:0]              w_nxt_grant;
    logic [PTR_W-1:0]               w_nxt_rr;

    // Flush beats stall, stall beats normal selection.
    always_comb begin
        w_mode = MODE_RUN;
        if (flush)
            w_mode = MODE_FLUSH;
        else if (cdb_stall)
            w_mode = MODE_STALL;
    end

    // An FU competes only with a real destination and if it was not just granted.
    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            w_eligible[i] = fu_req[i] && !r_grant[i] &&
                            (fu_rb_index[i*RB_INDEX +: RB_INDEX] != NULL);
        end
    end

    assign w_mask[0] = w_eligible;

    // Picker chain: each stage sees the mask minus all earlier winners.
    for (genvar k = 0; k < CDB_PORTS; k++) begin : g_pick
        cdb_rr_picker #(
            .N  (FU_NUM),
            .PW (PTR_W)
        ) u_pick (
            .i_mask   (w_mask[k]),
            .i_start  (r_rr_ptr),
            .o_onehot (w_onehot[k]),
            .o_index  (w_win_idx[k]),
            .o_valid  (w_win_valid[k])
        );
        if (k < CDB_PORTS - 1) begin : g_next
            assign w_mask[k+1] = w_mask[k] & ~w_onehot[k];
        end
    end

    // Route winners onto ports in scan order; the last winner sets the new pointer.
    always_comb begin
        w_nxt_valid    = '0;
        w_nxt_data     = '0;
        w_nxt_rb_index = {CDB_PORTS{NULL}};
        w_nxt_grant    = '0;
        w_nxt_rr       = r_rr_ptr;
        for (int k = 0; k < CDB_PORTS; k++) begin
            if (w_win_valid[k]) begin
                w_nxt_valid[k] = 1'b1;
                w_nxt_data[k*WORD_SIZE +: WORD_SIZE] =
                    fu_data[int'(w_win_idx[k])*WORD_SIZE +: WORD_SIZE];
                w_nxt_rb_index[k*RB_INDEX +: RB_INDEX] =
                    fu_rb_index[int'(w_win_idx[k])*RB_INDEX +: RB_INDEX];
                w_nxt_grant = w_nxt_grant | w_onehot[k];
                w_nxt_rr    = PTR_W'(ptr_wrap(int'(w_win_idx[k]) + 1, FU_NUM));
            end
        end
    end

    // Output, grant and pointer registers; stall holds the CDB but never re-grants.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_cdb_valid    <= '0;
            r_cdb_data     <= '0;
            r_cdb_rb_index <= {CDB_PORTS{NULL}};
        end else begin
            case (w_mode)
                MODE_FLUSH: begin
                    r_rr_ptr       <= '0;
                    r_grant        <= '0;
                    r_cdb_valid    <= '0;
                    r_cdb_data     <= '0;
                    r_cdb_rb_index <= {CDB_PORTS{NULL}};
                end
                MODE_STALL: begin
                    r_grant <= '0;
                end
                default: begin
                    r_rr_ptr       <= w_nxt_rr;
                    r_grant        <= w_nxt_grant;
                    r_cdb_valid    <= w_nxt_valid;
                    r_cdb_data     <= w_nxt_data;
                    r_cdb_rb_index <= w_nxt_rb_index;
                end
            endcase
        end
    end

    assign fu_grant     = r_grant;
    assign cdb_valid    = r_cdb_valid;
    assign cdb_data     = r_cdb_data;
    assign cdb_rb_index = r_cdb_rb_index;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates functional-unit (FU) results onto a fixed number of common-data-bus (CDB) broadcast ports. It sits between the FU result outputs and `CDB_data_controller` in the Tomasulo back end. Each cycle it selects up to `CDB_PORTS` requesting FUs in round-robin order and registers their data and reorder-buffer (RB) index onto the ports. It acknowledges each winner with a one-cycle grant pulse.

## Interface
Parameters:
- `WORD_SIZE`, 32: data width.
- `FU_NUM`, 6: number of requesting FUs.
- `RB_INDEX`, 4: RB index width.
- `NULL`, {RB_INDEX{1'b1}}: "no entry" index value.
- `CDB_PORTS`, 2: broadcast ports per cycle (1..FU_NUM).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous squash (mispredict).
- `fu_req`  in  FU_NUM  FU i holds a result.
- `fu_data`  in  WORD_SIZE*FU_NUM  result of FU i at bits [i*WORD_SIZE +: WORD_SIZE].
- `fu_rb_index`  in  RB_INDEX*FU_NUM  destination RB entry of FU i.
- `cdb_stall`  in  1  downstream cannot accept a new broadcast.
- `fu_grant`  out  FU_NUM  one-cycle acknowledge; FU i's result was taken.
- `cdb_valid`  out  CDB_PORTS  port p carries a result.
- `cdb_data`  out  WORD_SIZE*CDB_PORTS  per-port data.
- `cdb_rb_index`  out  RB_INDEX*CDB_PORTS  per-port RB index; `NULL` when the port is invalid.

## Operation
Eligibility: FU i is eligible when all of the following hold:
- `fu_req[i]` = 1;
- `fu_rb_index` slice i != `NULL`;
- `fu_grant[i]` = 0 this cycle.

An FU granted in cycle t is masked in cycle t+1. Each FU must drop `fu_req` or present its next result while its grant is high. A request carrying a `NULL` index is never granted and never blocks others.

Selection happens in each cycle with `flush` = 0 and `cdb_stall` = 0:
- Scan eligible FUs starting at `rr_ptr`, wrapping modulo FU_NUM, and take the first CDB_PORTS found.
- The k-th winner drives port k; ports are filled from 0 upward with no gaps.
- Unused ports: valid 0, data 0, index `NULL`.
- `rr_ptr` advances to (last winner + 1) mod FU_NUM. It is unchanged when nothing is granted.

Stall (`cdb_stall` = 1, `flush` = 0):
- All CDB outputs hold their values.
- `fu_grant` = 0.
- `rr_ptr` holds.
- No request is consumed.

Flush (has priority over stall and selection):
- Next edge: `cdb_valid` = 0, `cdb_data` = 0, all indices `NULL`, `fu_grant` = 0, `rr_ptr` = 0.
- Requests present in the flush cycle are ignored.

Reset values:
- `cdb_valid`, `cdb_data`, `fu_grant`: 0.
- `cdb_rb_index`: all `NULL`.
- `rr_ptr`: 0.

Asserting `reset` mid-broadcast clears outputs immediately; no partial result survives.

## Timing
- Latency: request sampled at edge t appears on the CDB and on `fu_grant` after edge t; 1 cycle.
- Per-FU throughput: at most one grant every 2 cycles, because of the grant mask.
- Aggregate throughput: CDB_PORTS results per unstalled cycle.
- `cdb_valid`, `cdb_data` and `cdb_rb_index` are registered; `fu_grant` is registered and aligned with them.
- `cdb_stall` and `flush` are sampled at the same edge as requests.

## Structure
- Shared constants `WORD_SIZE`, `FU_NUM`, `RB_INDEX` and `NULL` come from `parameters.v`. Add `CDB_PORTS` there.
- Sub-module `cdb_rr_picker`: combinational. Inputs are an eligibility mask and a start pointer; outputs are a one-hot first winner and its index. It is instantiated CDB_PORTS times in a chain, each stage removing the previous winner from the mask.
- Top level holds `rr_ptr`, the output registers and the grant register.

## Test plan
- Reset while `fu_req` = 6'h3F -> all outputs 0, `cdb_rb_index` = 8'hFF; after release, first grants go to FU0 and FU1.
- FU2 alone requests, data 0x1234, index 5 -> next cycle: `cdb_valid` = 2'b01, port0 = 0x1234 / 5, port1 index = NULL, `fu_grant` = 6'b000100, `rr_ptr` = 3.
- All six FUs request continuously from reset -> grants {0,1}, {2,3}, {4,5}, {0,1} on successive cycles; no FU is granted on two consecutive cycles.
- Port0 valid = FU3 result; assert `cdb_stall` for 3 cycles with FU4 and FU5 requesting -> CDB outputs hold, `fu_grant` = 0; after release, grants {4,5}.
- `flush` during the all-request stream with `rr_ptr` = 4 -> next cycle `cdb_valid` = 0, `fu_grant` = 0; first post-flush grants {0,1}.
- FU3 requests with index 4'hF and FU4 with index 7 -> only FU4 granted, on port0; FU3 is never granted and `rr_ptr` = 5.
